// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
//   Initiator for the external 16-bit asynchronous SRAM. Each 32-bit load or
//   store from the MEM stage is split into two half-word accesses: LOW
//   (bits [15:0]) and then HIGH (bits [31:16]). ready stays low while the
//   accesses run, which freezes the pipeline.
//
//   Request handshake: the MEM stage raises rd_en or wr_en and holds it,
//   together with address/write_data, until it sees ready=1. ready=1 with no
//   request means idle. ready=1 in DONE means the word access has finished.
//   A request seen in DONE is not accepted; it is accepted once the FSM is
//   back in IDLE, so there is always at least one idle cycle between words.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   wr_en/rd_en  store/load request (both high is a store)
//   address      CPU byte address (bits [1:0] ignored)
//   write_data   store data
//   read_data    load result, held until the next load
//   ready        0 = stall the pipeline
//   SRAMaddress  half-word address on the SRAM pins
//   SRAMWEn      SRAM write enable, active low
//   SRAMOE       SRAM output enable, active low
//   SRAMdata     bidirectional SRAM data bus
//   fsm_state    debug view of the FSM state (0 IDLE, 1 LOW, 2 HIGH, 3 DONE)
// ----------------------------------------------------------------------------
module sram_controller #(
   parameter logic [31:0] ADDR_BASE     = 32'd1024,
   parameter int          ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] SRAMaddress,
   output logic        SRAMWEn,
   output logic        SRAMOE,
   inout  wire  [15:0] SRAMdata,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   // Last cycle of a phase, and the cycle in which a write releases WEn so
   // the data is held for one cycle before the address changes.
   localparam logic [3:0] LAST_CYCLE = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0] HOLD_CYCLE = 4'(ACCESS_CYCLES - 2);

   state_t      state;
   logic [3:0]  cnt;
   logic        is_write;
   logic [31:0] offs;
   logic        drive;
   logic        unused_offs_bits;

   assign offs             = address - ADDR_BASE;
   assign unused_offs_bits = ^{offs[31:19], offs[1:0]};

   // The bus is driven only during write phases; SRAMOE is held high then,
   // so controller and SRAM never drive at the same time.
   assign drive    = is_write & ((state == LOW) | (state == HIGH));
   assign SRAMdata = drive ? ((state == HIGH) ? write_data[31:16] : write_data[15:0])
                           : 16'hzzzz;

   assign ready     = (state == DONE) | ((state == IDLE) & ~rd_en & ~wr_en);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         is_write    <= 1'b0;
         read_data   <= 32'd0;
         SRAMaddress <= 18'd0;
         SRAMWEn     <= 1'b1;
         SRAMOE      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (rd_en | wr_en) begin
                  state       <= LOW;
                  cnt         <= 4'd0;
                  is_write    <= wr_en;
                  SRAMaddress <= {offs[18:2], 1'b0};
                  SRAMWEn     <= ~wr_en;
                  SRAMOE      <= wr_en;
               end
            end
            LOW: begin
               if (cnt == LAST_CYCLE) begin
                  if (!is_write) read_data[15:0] <= SRAMdata;
                  state       <= HIGH;
                  cnt         <= 4'd0;
                  SRAMaddress <= {offs[18:2], 1'b1};
                  SRAMWEn     <= ~is_write;
                  SRAMOE      <= is_write;
               end else begin
                  cnt <= cnt + 4'd1;
                  if (is_write && cnt == HOLD_CYCLE) SRAMWEn <= 1'b1;
               end
            end
            HIGH: begin
               if (cnt == LAST_CYCLE) begin
                  if (!is_write) read_data[31:16] <= SRAMdata;
                  state   <= DONE;
                  cnt     <= 4'd0;
                  SRAMWEn <= 1'b1;
                  SRAMOE  <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
                  if (is_write && cnt == HOLD_CYCLE) SRAMWEn <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// ----------------------------------------------------------------------------
// tb_sram_controller
//   Directed bench for sram_controller. The SRAM model returns 16'h0400
//   whenever SRAMOE is low and records every half-word written while SRAMWEn
//   is low. Cycle 0 is the IDLE cycle in which a request is first presented.
//   Inputs change 2 ns after a rising edge; outputs are checked right after.
// ----------------------------------------------------------------------------
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_address;
   logic        sram_we_n;
   logic        sram_oe;
   wire  [15:0] sram_data;
   logic [1:0]  fsm_state;

   logic [15:0] mem [0:31];
   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sram_controller dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .ready       (ready),
      .SRAMaddress (sram_address),
      .SRAMWEn     (sram_we_n),
      .SRAMOE      (sram_oe),
      .SRAMdata    (sram_data),
      .fsm_state   (fsm_state)
   );

   // SRAM model
   assign sram_data = (sram_oe === 1'b0) ? 16'h0400 : 16'hzzzz;

   always @(posedge clk) begin
      if (sram_we_n === 1'b0) mem[sram_address[4:0]] <= sram_data;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
      repeat (2) @(posedge clk);
      #2;
      vectors++;
      if (sram_we_n !== 1'b1 || sram_oe !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_strobes: got we_n=%b oe=%b want we_n=1 oe=1", sram_we_n, sram_oe);
      end
      vectors++;
      if (ready !== 1'b1 || read_data !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_ready_data: got ready=%b read_data=%h want ready=1 read_data=00000000", ready, read_data);
      end
      vectors++;
      if (sram_address !== 18'd0 || fsm_state !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_state: got addr=%0d state=%0d want addr=0 state=0", sram_address, fsm_state);
      end
      rst = 1'b0;
   endtask

   task automatic test_read();
      logic [17:0] exp_a;
      rd_en = 1'b1; address = 32'd1024;
      #1;
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL read_c0_ready: got %b want 0", ready);
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp_a = (k <= 2) ? 18'd0 : 18'd1;
         vectors++;
         if (sram_address !== exp_a) begin
            miscompares++;
            $display("FAIL read_addr_c%0d: got %0d want %0d", k, sram_address, exp_a);
         end
         vectors++;
         if (sram_oe !== 1'b0 || sram_we_n !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL read_strobes_c%0d: got oe=%b we_n=%b ready=%b want oe=0 we_n=1 ready=0",
                     k, sram_oe, sram_we_n, ready);
         end
      end
      tick();
      vectors++;
      if (ready !== 1'b1 || read_data !== 32'h0400_0400 || fsm_state !== 2'd3) begin
         miscompares++;
         $display("FAIL read_done: got ready=%b data=%h state=%0d want ready=1 data=04000400 state=3",
                  ready, read_data, fsm_state);
      end
      rd_en = 1'b0;
      tick();
      vectors++;
      if (fsm_state !== 2'd0 || ready !== 1'b1 || sram_oe !== 1'b1) begin
         miscompares++;
         $display("FAIL read_idle: got state=%0d ready=%b oe=%b want state=0 ready=1 oe=1",
                  fsm_state, ready, sram_oe);
      end
   endtask

   task automatic test_write();
      logic [17:0] exp_a;
      logic        exp_we;
      logic [15:0] exp_d;
      wr_en = 1'b1; address = 32'd1032; write_data = 32'hDEAD_BEEF;
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp_a  = (k <= 2) ? 18'd4 : 18'd5;
         exp_we = (k % 2 == 1) ? 1'b0 : 1'b1;
         exp_d  = (k <= 2) ? 16'hBEEF : 16'hDEAD;
         vectors++;
         if (sram_address !== exp_a || sram_we_n !== exp_we || sram_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL write_pins_c%0d: got addr=%0d we_n=%b oe=%b want addr=%0d we_n=%b oe=1",
                     k, sram_address, sram_we_n, sram_oe, exp_a, exp_we);
         end
         vectors++;
         if (sram_data !== exp_d) begin
            miscompares++;
            $display("FAIL write_data_c%0d: got %h want %h", k, sram_data, exp_d);
         end
      end
      tick();
      vectors++;
      if (ready !== 1'b1 || read_data !== 32'h0400_0400) begin
         miscompares++;
         $display("FAIL write_done: got ready=%b read_data=%h want ready=1 read_data=04000400",
                  ready, read_data);
      end
      wr_en = 1'b0;
      tick();
      vectors++;
      if (mem[4] !== 16'hBEEF || mem[5] !== 16'hDEAD) begin
         miscompares++;
         $display("FAIL write_mem: got mem4=%h mem5=%h want BEEF DEAD", mem[4], mem[5]);
      end
   endtask

   task automatic test_simultaneous();
      rd_en = 1'b1; wr_en = 1'b1; address = 32'd1028; write_data = 32'h1234_5678;
      for (int k = 1; k <= 4; k++) begin
         tick();
         vectors++;
         if (sram_oe !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_c%0d: got oe=%b ready=%b want oe=1 ready=0", k, sram_oe, ready);
         end
      end
      tick();
      vectors++;
      if (ready !== 1'b1 || read_data !== 32'h0400_0400) begin
         miscompares++;
         $display("FAIL simul_done: got ready=%b read_data=%h want ready=1 read_data=04000400",
                  ready, read_data);
      end
      rd_en = 1'b0; wr_en = 1'b0;
      tick();
      vectors++;
      if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin
         miscompares++;
         $display("FAIL simul_mem: got mem2=%h mem3=%h want 5678 1234", mem[2], mem[3]);
      end
   endtask

   task automatic test_reset_mid_op();
      rd_en = 1'b1; address = 32'd1040;
      repeat (3) tick();
      vectors++;
      if (fsm_state !== 2'd2 || sram_address !== 18'd9) begin
         miscompares++;
         $display("FAIL midrst_high: got state=%0d addr=%0d want state=2 addr=9", fsm_state, sram_address);
      end
      rst = 1'b1; rd_en = 1'b0;
      tick();
      vectors++;
      if (fsm_state !== 2'd0 || sram_oe !== 1'b1 || sram_we_n !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_state: got state=%0d oe=%b we_n=%b want state=0 oe=1 we_n=1",
                  fsm_state, sram_oe, sram_we_n);
      end
      vectors++;
      if (read_data !== 32'd0 || ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_data: got read_data=%h ready=%b want 00000000 ready=1", read_data, ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_drop();
      rd_en = 1'b1; address = 32'd1064;
      tick();
      vectors++;
      if (fsm_state !== 2'd1 || sram_address !== 18'd20) begin
         miscompares++;
         $display("FAIL drop_low: got state=%0d addr=%0d want state=1 addr=20", fsm_state, sram_address);
      end
      rd_en = 1'b0;
      for (int k = 2; k <= 4; k++) begin
         tick();
         vectors++;
         if (ready !== 1'b0 || sram_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_run_c%0d: got ready=%b oe=%b want ready=0 oe=0", k, ready, sram_oe);
         end
      end
      vectors++;
      if (fsm_state !== 2'd2 || sram_address !== 18'd21) begin
         miscompares++;
         $display("FAIL drop_high: got state=%0d addr=%0d want state=2 addr=21", fsm_state, sram_address);
      end
      tick();
      vectors++;
      if (fsm_state !== 2'd3 || ready !== 1'b1 || read_data !== 32'h0400_0400) begin
         miscompares++;
         $display("FAIL drop_done: got state=%0d ready=%b data=%h want state=3 ready=1 data=04000400",
                  fsm_state, ready, read_data);
      end
      tick();
      vectors++;
      if (fsm_state !== 2'd0 || ready !== 1'b1) begin
         miscompares++;
         $display("FAIL drop_idle: got state=%0d ready=%b want state=0 ready=1", fsm_state, ready);
      end
   endtask

   task automatic test_back_to_back();
      rd_en = 1'b1; address = 32'd1024;
      repeat (5) tick();
      vectors++;
      if (ready !== 1'b1 || fsm_state !== 2'd3) begin
         miscompares++;
         $display("FAIL b2b_first_done: got ready=%b state=%0d want ready=1 state=3", ready, fsm_state);
      end
      // Pipeline advances: next load presented while still in DONE.
      address = 32'd1036;
      tick();
      vectors++;
      if (fsm_state !== 2'd0 || ready !== 1'b0 || sram_oe !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_gap: got state=%0d ready=%b oe=%b want state=0 ready=0 oe=1",
                  fsm_state, ready, sram_oe);
      end
      tick();
      vectors++;
      if (fsm_state !== 2'd1 || sram_address !== 18'd6 || sram_oe !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_second_low: got state=%0d addr=%0d oe=%b want state=1 addr=6 oe=0",
                  fsm_state, sram_address, sram_oe);
      end
      repeat (2) tick();
      vectors++;
      if (fsm_state !== 2'd2 || sram_address !== 18'd7) begin
         miscompares++;
         $display("FAIL b2b_second_high: got state=%0d addr=%0d want state=2 addr=7", fsm_state, sram_address);
      end
      repeat (2) tick();
      vectors++;
      if (ready !== 1'b1 || read_data !== 32'h0400_0400) begin
         miscompares++;
         $display("FAIL b2b_second_done: got ready=%b data=%h want ready=1 data=04000400", ready, read_data);
      end
      rd_en = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
      test_reset();
      test_read();
      test_write();
      test_simultaneous();
      test_reset_mid_op();
      test_drop();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
